// File: rtl/ssram_stream_reader_pkg.sv
// Shared definitions for the ramDma SSRAM block movers: FSM encoding and
// address-width derivation used by both the stream reader and the bus-side writer.
package ssram_stream_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_WIDTH   = 32;
  localparam int unsigned DEFAULT_ENTRIES = 512;

  function automatic int unsigned addr_width(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

endpackage

// File: rtl/ssram_skid_fifo.sv
// Two-entry synchronous FIFO with registered head, occupancy count,
// simultaneous push/pop and synchronous clear.
module ssram_skid_fifo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] tail_data;
  logic             do_pop;
  logic [1:0]       count_next;

  assign do_pop = pop && head_valid;

  always_comb begin
    count_next = count;
    case ({push, do_pop})
      2'b10:   count_next = 2'(count + 2'd1);
      2'b01:   count_next = 2'(count - 2'd1);
      default: count_next = count;
    endcase
  end

  // Entry 0 is always the head so the stream output comes straight from a flop.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      head_data  <= '0;
      tail_data  <= '0;
      count      <= 2'd0;
      head_valid <= 1'b0;
    end else begin
      count      <= count_next;
      head_valid <= (count_next != 2'd0);
      case ({push, do_pop})
        2'b10: begin
          if (count == 2'd0) head_data <= push_data;
          else               tail_data <= push_data;
        end
        2'b01: head_data <= tail_data;
        2'b11: begin
          if (count == 2'd2) begin
            head_data <= tail_data;
            tail_data <= push_data;
          end else begin
            head_data <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ssram_stream_reader.sv
// Read-side DMA engine: streams a block of consecutive SSRAM words out on a
// valid/ready interface, keeping at most two words buffered or in flight.
module ssram_stream_reader
  import ssram_stream_reader_pkg::*;
#(
  parameter int unsigned bitwidth    = DEFAULT_WIDTH,
  parameter int unsigned nrOfEntries = DEFAULT_ENTRIES,
  localparam int unsigned AW         = addr_width(nrOfEntries)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [AW-1:0]       startAddress,
  input  logic [AW:0]         blockSize,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       ramAddress,
  output logic                ramWriteEnable,
  input  logic [bitwidth-1:0] ramDataIn,
  output logic [bitwidth-1:0] dataOut,
  output logic                dataValid,
  input  logic                dataReady
);

  localparam int unsigned CW = AW + 1;

  state_t        state, state_next;
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] xfer_cnt;
  logic          in_flight;
  logic [1:0]    buf_count;
  logic [1:0]    occ_next;
  logic          accept;
  logic          issue;
  logic          pop;
  logic [AW-1:0] addr_inc;

  assign ramWriteEnable = 1'b0;

  assign pop      = dataValid && dataReady;
  assign addr_inc = (ramAddress == AW'(nrOfEntries - 1)) ? '0 : AW'(ramAddress + AW'(1));

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    // Occupancy after this edge, before counting a read issued now.
    occ_next   = 2'(buf_count + {1'b0, in_flight} - {1'b0, pop});
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (blockSize == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        issue = (occ_next < 2'd2) && (issue_cnt != '0);
        if (issue && (issue_cnt == CW'(1))) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && (xfer_cnt == CW'(1))) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Address and counters; ramAddress keeps the last issued address once the block is issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      ramAddress <= '0;
      issue_cnt  <= '0;
      xfer_cnt   <= '0;
      in_flight  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      in_flight <= issue;
      busy      <= (state_next == ST_FETCH) || (state_next == ST_DRAIN);
      done      <= (state_next == ST_DONE);
      if (accept) begin
        ramAddress <= startAddress;
        issue_cnt  <= blockSize;
        xfer_cnt   <= blockSize;
      end else begin
        if (issue) begin
          issue_cnt <= CW'(issue_cnt - CW'(1));
          if (issue_cnt != CW'(1)) ramAddress <= addr_inc;
        end
        if (pop && (xfer_cnt != '0)) xfer_cnt <= CW'(xfer_cnt - CW'(1));
      end
    end
  end

  ssram_skid_fifo #(
    .WIDTH(bitwidth)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear      (accept),
    .push       (in_flight),
    .push_data  (ramDataIn),
    .pop        (dataReady),
    .head_data  (dataOut),
    .head_valid (dataValid),
    .count      (buf_count)
  );

endmodule

// File: tb/tb_ssram_stream_reader.sv
// Directed bench for ssram_stream_reader with a one-cycle-latency SSRAM model.
module tb_ssram_stream_reader;

  logic        clock;
  logic        reset;
  logic        start;
  logic [8:0]  start_address;
  logic [9:0]  block_size;
  logic        busy;
  logic        done;
  logic [8:0]  ram_address;
  logic        ram_we;
  logic [31:0] ram_q;
  logic [31:0] data_out;
  logic        data_valid;
  logic        data_ready;

  logic [31:0] mem [512];

  int n_checks;
  int n_errors;

  ssram_stream_reader #(
    .bitwidth    (32),
    .nrOfEntries (512)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .startAddress   (start_address),
    .blockSize      (block_size),
    .busy           (busy),
    .done           (done),
    .ramAddress     (ram_address),
    .ramWriteEnable (ram_we),
    .ramDataIn      (ram_q),
    .dataOut        (data_out),
    .dataValid      (data_valid),
    .dataReady      (data_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) ram_q <= mem[ram_address];

  // Pulses start for one cycle; returns at the falling edge of the first cycle after acceptance.
  task automatic do_start(input logic [8:0] a, input logic [9:0] n);
    @(negedge clock);
    start = 1'b1;
    start_address = a;
    block_size = n;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if ({busy, done, data_valid, ram_we} !== 4'b0000) begin
      $display("FAIL reset_flags busy/done/valid/we=%b expected 0000", {busy, done, data_valid, ram_we});
      n_errors++;
    end
    n_checks++;
    if (ram_address !== 9'd0 || data_out !== 32'd0) begin
      $display("FAIL reset_values addr=%0h data=%0h expected 0/0", ram_address, data_out);
      n_errors++;
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    data_ready = 1'b1;
    do_start(9'd4, 10'd8);
    n_checks++;
    if (ram_address !== 9'd4 || busy !== 1'b1 || data_valid !== 1'b0) begin
      $display("FAIL basic_c1 addr=%0h busy=%b valid=%b expected 4/1/0", ram_address, busy, data_valid);
      n_errors++;
    end
    @(negedge clock);
    n_checks++;
    if (data_valid !== 1'b0) begin
      $display("FAIL basic_c2_valid got %b expected 0", data_valid);
      n_errors++;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      n_checks++;
      if (data_valid !== 1'b1 || data_out !== 32'h104 + 32'(k)) begin
        $display("FAIL basic_word%0d valid=%b data=%0h expected 1/%0h", k, data_valid, data_out, 32'h104 + 32'(k));
        n_errors++;
      end
    end
    @(negedge clock);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || data_valid !== 1'b0) begin
      $display("FAIL basic_done done=%b busy=%b valid=%b expected 1/0/0", done, busy, data_valid);
      n_errors++;
    end
    @(negedge clock);
    n_checks++;
    if (done !== 1'b0) begin
      $display("FAIL basic_done_pulse got %b expected 0", done);
      n_errors++;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp [4];
    exp[0] = 32'h2FE; exp[1] = 32'h2FF; exp[2] = 32'h100; exp[3] = 32'h101;
    data_ready = 1'b1;
    do_start(9'd510, 10'd4);
    @(negedge clock);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_checks++;
      if (data_valid !== 1'b1 || data_out !== exp[k]) begin
        $display("FAIL wrap_word%0d valid=%b data=%0h expected 1/%0h", k, data_valid, data_out, exp[k]);
        n_errors++;
      end
    end
    @(negedge clock);
    n_checks++;
    if (done !== 1'b1) begin
      $display("FAIL wrap_done got %b expected 1", done);
      n_errors++;
    end
  endtask

  task automatic test_backpressure();
    int          idx;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        seen_done;
    idx = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    seen_done = 1'b0;
    data_ready = 1'b0;
    do_start(9'd20, 10'd16);
    for (int c = 0; c < 200 && !seen_done; c++) begin
      if (prev_stall) begin
        n_checks++;
        if (data_valid !== 1'b1 || data_out !== prev_data) begin
          $display("FAIL bp_stall valid=%b data=%0h expected 1/%0h", data_valid, data_out, prev_data);
          n_errors++;
        end
      end
      n_checks++;
      if (32'(dut.buf_count) + 32'(dut.in_flight) > 2) begin
        $display("FAIL bp_occupancy got %0d expected <=2", 32'(dut.buf_count) + 32'(dut.in_flight));
        n_errors++;
      end
      if (done === 1'b1) seen_done = 1'b1;
      data_ready = 1'($urandom_range(1, 0));
      if (data_valid === 1'b1 && data_ready) begin
        n_checks++;
        if (idx >= 16 || data_out !== 32'h114 + 32'(idx)) begin
          $display("FAIL bp_word%0d data=%0h expected %0h", idx, data_out, 32'h114 + 32'(idx));
          n_errors++;
        end
        idx++;
      end
      prev_stall = data_valid && !data_ready;
      prev_data = data_out;
      if (!seen_done) @(negedge clock);
    end
    n_checks++;
    if (!seen_done || idx != 16) begin
      $display("FAIL bp_total words=%0d done_seen=%b expected 16/1", idx, seen_done);
      n_errors++;
    end
    data_ready = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_size_zero();
    data_ready = 1'b1;
    do_start(9'd7, 10'd0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || data_valid !== 1'b0) begin
      $display("FAIL zero_c1 done=%b busy=%b valid=%b expected 1/0/0", done, busy, data_valid);
      n_errors++;
    end
    @(negedge clock);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || data_valid !== 1'b0) begin
      $display("FAIL zero_c2 done=%b busy=%b valid=%b expected 0/0/0", done, busy, data_valid);
      n_errors++;
    end
  endtask

  task automatic test_start_while_busy();
    int   cnt;
    logic seen_done;
    cnt = 0;
    seen_done = 1'b0;
    data_ready = 1'b1;
    do_start(9'd100, 10'd8);
    for (int c = 1; c < 40 && !seen_done; c++) begin
      if (data_valid === 1'b1) begin
        n_checks++;
        if (cnt >= 8 || data_out !== 32'h164 + 32'(cnt)) begin
          $display("FAIL busy_word%0d data=%0h expected %0h", cnt, data_out, 32'h164 + 32'(cnt));
          n_errors++;
        end
        cnt++;
      end
      if (done === 1'b1) seen_done = 1'b1;
      // Second command while busy, and another in the DONE cycle; both must be ignored.
      start = (c == 3) || (done === 1'b1);
      start_address = 9'd300;
      block_size = 10'd2;
      @(negedge clock);
      start = 1'b0;
    end
    n_checks++;
    if (!seen_done || cnt != 8) begin
      $display("FAIL busy_total words=%0d done_seen=%b expected 8/1", cnt, seen_done);
      n_errors++;
    end
    @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || data_valid !== 1'b0 || done !== 1'b0) begin
      $display("FAIL busy_after busy=%b valid=%b done=%b expected 0/0/0", busy, data_valid, done);
      n_errors++;
    end
  endtask

  task automatic test_reset_mid();
    data_ready = 1'b1;
    do_start(9'd40, 10'd8);
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_checks++;
      if (data_valid !== 1'b1 || data_out !== 32'h128 + 32'(k)) begin
        $display("FAIL rst_word%0d valid=%b data=%0h expected 1/%0h", k, data_valid, data_out, 32'h128 + 32'(k));
        n_errors++;
      end
    end
    data_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({busy, done, data_valid, ram_we} !== 4'b0000 || ram_address !== 9'd0 || data_out !== 32'd0) begin
      $display("FAIL rst_mid flags=%b addr=%0h data=%0h expected 0000/0/0", {busy, done, data_valid, ram_we}, ram_address, data_out);
      n_errors++;
    end
    reset = 1'b0;
    data_ready = 1'b1;
    @(negedge clock);
    n_checks++;
    if (data_valid !== 1'b0) begin
      $display("FAIL rst_stale valid=%b expected 0", data_valid);
      n_errors++;
    end
    do_start(9'd0, 10'd2);
    n_checks++;
    if (data_valid !== 1'b0) begin
      $display("FAIL rst_new_c1 valid=%b expected 0", data_valid);
      n_errors++;
    end
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      n_checks++;
      if (data_valid !== 1'b1 || data_out !== 32'h100 + 32'(k)) begin
        $display("FAIL rst_new_word%0d valid=%b data=%0h expected 1/%0h", k, data_valid, data_out, 32'h100 + 32'(k));
        n_errors++;
      end
    end
    @(negedge clock);
    n_checks++;
    if (done !== 1'b1 || data_valid !== 1'b0) begin
      $display("FAIL rst_new_done done=%b valid=%b expected 1/0", done, data_valid);
      n_errors++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 512; i++) mem[i] = 32'h100 + 32'(i);
    reset = 1'b1;
    start = 1'b0;
    start_address = '0;
    block_size = '0;
    data_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_size_zero();
    test_start_while_busy();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
